// File: rtl/run_detect_pkg.sv
// Shared types and constants for the run-length detector.
package run_detect_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } run_state_t;

  localparam logic MODE_NOVL = 1'b0;
  localparam logic MODE_OVL  = 1'b1;

  // Counter width able to hold 0..run_len
  function automatic int cnt_width(input int run_len);
    return $clog2(run_len + 1);
  endfunction

endpackage

// File: rtl/run_detect_fsm_if.sv
// Data/control bundle of the run detector; hit_count exists only with RUN_DETECT_STATS_EN.
interface run_detect_fsm_if #(
  parameter int LEN_W = 8
`ifdef RUN_DETECT_STATS_EN
  , parameter int STAT_W = 16
`endif
) ();

  logic             clear;
  logic             mode_ovl;
  logic             in_valid;
  logic             in;
  logic             out;
  logic [LEN_W-1:0] run_len;
`ifdef RUN_DETECT_STATS_EN
  logic [STAT_W-1:0] hit_count;
`endif

`ifdef RUN_DETECT_STATS_EN
  modport master (
    output clear, mode_ovl, in_valid, in,
    input  out, run_len, hit_count
  );

  modport slave (
    input  clear, mode_ovl, in_valid, in,
    output out, run_len, hit_count
  );
`else
  modport master (
    output clear, mode_ovl, in_valid, in,
    input  out, run_len
  );

  modport slave (
    input  clear, mode_ovl, in_valid, in,
    output out, run_len
  );
`endif

endinterface

// File: rtl/sat_counter.sv
// Registered up-counter with synchronous clear; saturates at all-ones or wraps.
module sat_counter #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;
  logic             w_at_max;
  logic             w_step;

  assign w_at_max = &r_q;
  assign w_step   = i_inc && !(SATURATE && w_at_max);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (w_step) begin
      r_q <= r_q + WIDTH'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/run_detect_fsm.sv
// Mealy detector for runs of RUN_LEN accepted ones, overlap/non-overlap modes.
// Optional hit statistics counter enabled by macro RUN_DETECT_STATS_EN.
//   state   | meaning
//   ST_IDLE | no ones pending, count 0
//   ST_RUN  | 0 < count < RUN_LEN
//   ST_HIT  | previous accepted bit produced a hit
module run_detect_fsm
  import run_detect_pkg::*;
#(
  parameter int RUN_LEN = 2,
  parameter int LEN_W   = 8
`ifdef RUN_DETECT_STATS_EN
  , parameter int STAT_W = 16
`endif
) (
  input  logic           clk,
  input  logic           rst,
  run_detect_fsm_if.slave bus
);

  localparam int             CW      = cnt_width(RUN_LEN);
  localparam logic [CW-1:0]  CNT_MAX = CW'(RUN_LEN - 1);

  run_state_t    r_state;
  run_state_t    w_state_nxt;
  logic [CW-1:0] r_cnt_q;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_accept;
  logic          w_hit;
  logic          w_out;
  logic          w_len_clr;
  logic          w_len_inc;
  logic [LEN_W-1:0] w_run_len;

  assign w_accept = bus.in_valid && !bus.clear;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt_q <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt_q <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt_q;
    w_hit       = w_accept && bus.in &&
                  ((r_cnt_q == CNT_MAX) ||
                   (r_state == ST_HIT && bus.mode_ovl == MODE_OVL));

    if (bus.clear) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
    end else if (w_accept) begin
      if (!bus.in) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end else if (w_hit) begin
        // Overlap parks the count at the threshold so every further one hits.
        w_state_nxt = ST_HIT;
        w_cnt_nxt   = (bus.mode_ovl == MODE_OVL) ? CNT_MAX : '0;
      end else begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = r_cnt_q + CW'(1);
      end
    end
  end

  assign w_out   = w_hit && !rst;
  assign bus.out = w_out;

  assign w_len_clr = bus.clear || (w_accept && !bus.in);
  assign w_len_inc = w_accept && bus.in;

  sat_counter #(
    .WIDTH    (LEN_W),
    .SATURATE (1'b1)
  ) u_run_len (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_len_clr),
    .i_inc (w_len_inc),
    .o_q   (w_run_len)
  );

  assign bus.run_len = w_run_len;

`ifdef RUN_DETECT_STATS_EN
  logic [STAT_W-1:0] w_hit_count;

  // Statistics survive clear; only rst zeroes them.
  sat_counter #(
    .WIDTH    (STAT_W),
    .SATURATE (1'b0)
  ) u_hit_count (
    .clk   (clk),
    .rst   (rst),
    .i_clr (1'b0),
    .i_inc (w_out),
    .o_q   (w_hit_count)
  );

  assign bus.hit_count = w_hit_count;
`endif

endmodule

// File: tb/tb_run_detect_fsm.sv
// Bench for run_detect_fsm: four instances (RUN_LEN 2,3,1,4) share one stimulus stream.
module tb_run_detect_fsm;

  logic clk;
  logic t_rst, t_clear, t_valid, t_in, t_ovl;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  run_detect_fsm_if #(.LEN_W(8)) if0 ();
  run_detect_fsm_if #(.LEN_W(8)) if1 ();
  run_detect_fsm_if #(.LEN_W(2)) if2 ();
  run_detect_fsm_if #(.LEN_W(8)) if3 ();

  assign if0.clear = t_clear; assign if0.mode_ovl = t_ovl; assign if0.in_valid = t_valid; assign if0.in = t_in;
  assign if1.clear = t_clear; assign if1.mode_ovl = t_ovl; assign if1.in_valid = t_valid; assign if1.in = t_in;
  assign if2.clear = t_clear; assign if2.mode_ovl = t_ovl; assign if2.in_valid = t_valid; assign if2.in = t_in;
  assign if3.clear = t_clear; assign if3.mode_ovl = t_ovl; assign if3.in_valid = t_valid; assign if3.in = t_in;

  run_detect_fsm #(.RUN_LEN(2), .LEN_W(8)) u0 (.clk(clk), .rst(t_rst), .bus(if0.slave));
  run_detect_fsm #(.RUN_LEN(3), .LEN_W(8)) u1 (.clk(clk), .rst(t_rst), .bus(if1.slave));
  run_detect_fsm #(.RUN_LEN(1), .LEN_W(2)) u2 (.clk(clk), .rst(t_rst), .bus(if2.slave));
  run_detect_fsm #(.RUN_LEN(4), .LEN_W(8)) u3 (.clk(clk), .rst(t_rst), .bus(if3.slave));

  logic [3:0] act_out;
  logic [7:0] act_len [4];
  assign act_out[0] = if0.out;
  assign act_out[1] = if1.out;
  assign act_out[2] = if2.out;
  assign act_out[3] = if3.out;
  assign act_len[0] = if0.run_len;
  assign act_len[1] = if1.run_len;
  assign act_len[2] = {6'b0, if2.run_len};
  assign act_len[3] = if3.run_len;
`ifdef RUN_DETECT_STATS_EN
  logic [15:0] act_hc [4];
  assign act_hc[0] = if0.hit_count;
  assign act_hc[1] = if1.hit_count;
  assign act_hc[2] = if2.hit_count;
  assign act_hc[3] = if3.hit_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  int rl_tab  [4];
  int max_tab [4];

  // Reference model: length of the current run of accepted ones, and hit totals.
  int   m_run;
  int   m_hc  [4];
  logic m_out [4];

  logic s_out [4];
  int   s_len [4];
  int   s_hc  [4];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_hit(input int run, input int r, input logic ovl);
    if (ovl) return (run + 1) >= r;
    return ((run + 1) % r) == 0;
  endfunction

  task automatic step(input logic c, input logic v, input logic d, input logic ovl, input logic r);
    @(negedge clk);
    t_rst = r; t_clear = c; t_valid = v; t_in = d; t_ovl = ovl;
    #1;
    for (int k = 0; k < 4; k++) begin
      s_out[k] = act_out[k];
      m_out[k] = !r && v && !c && d && model_hit(m_run, rl_tab[k], ovl);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      s_len[k] = int'(act_len[k]);
`ifdef RUN_DETECT_STATS_EN
      s_hc[k] = int'(act_hc[k]);
`else
      s_hc[k] = 0;
`endif
    end
    if (r) begin
      m_run = 0;
      for (int k = 0; k < 4; k++) m_hc[k] = 0;
    end else begin
      for (int k = 0; k < 4; k++) m_hc[k] = (m_hc[k] + int'(m_out[k])) & 16'hFFFF;
      if (c) m_run = 0;
      else if (v) m_run = d ? m_run + 1 : 0;
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Feed n accepted ones and compare one instance's out against a bit mask.
  task automatic ones(input int n, input logic ovl, input int inst, input int mask, input string name);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 1'b1, ovl, 1'b0);
      chk(name, int'(s_out[inst]), (mask >> i) & 1);
    end
  endtask

  typedef struct {
    logic clear;
    logic valid;
    logic din;
    logic exp_out;
    int   exp_len;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic r_ovl;
    int   min_len;
    t_rst = 1'b1; t_clear = 1'b0; t_valid = 1'b0; t_in = 1'b0; t_ovl = 1'b0;
    rl_tab  = '{2, 3, 1, 4};
    max_tab = '{255, 255, 3, 255};
    m_run = 0;
    for (int k = 0; k < 4; k++) m_hc[k] = 0;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 2};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 3};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 2};

    // Reset: out forced low while rst is high even with an accepted one.
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk("rst_out", int'(s_out[k]), 0);
      chk("rst_len", s_len[k], 0);
      chk("rst_hc", s_hc[k], 0);
    end

    // RUN_LEN=2 overlap table on instance 0
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].clear, tbl[i].valid, tbl[i].din, 1'b1, 1'b0);
      chk("tbl_out", int'(s_out[0]), int'(tbl[i].exp_out));
      chk("tbl_len", s_len[0], tbl[i].exp_len);
    end

    // RUN_LEN=3 non-overlap then overlap; RUN_LEN=1 saturating length on the same stream
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("novl_r3", int'(s_out[1]), (i == 2 || i == 5) ? 1 : 0);
      chk("r1_out", int'(s_out[2]), 1);
      chk("r1_sat_len", s_len[2], (i < 3) ? i + 1 : 3);
    end
    do_reset();
    ones(7, 1'b1, 1, 124, "ovl_r3");

    // Gap in in_valid holds the partial run
    do_reset();
    ones(2, 1'b0, 1, 0, "gap_pre");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("gap_out", int'(s_out[1]), 0);
      chk("gap_len", s_len[1], 2);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("gap_resume", int'(s_out[1]), 1);
    chk("gap_len_after", s_len[1], 3);

    // Clear beats in_valid and discards the partial run
    do_reset();
    ones(2, 1'b0, 1, 0, "clr_pre");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("clr_out", int'(s_out[1]), 0);
    chk("clr_len", s_len[1], 0);
    ones(3, 1'b0, 1, 4, "clr_post");

    // Reset mid-run with RUN_LEN=4
    do_reset();
    ones(3, 1'b0, 3, 0, "mrst_pre");
    chk("mrst_len_pre", s_len[3], 3);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("mrst_out", int'(s_out[3]), 0);
    for (int k = 0; k < 4; k++) begin
      chk("mrst_len", s_len[k], 0);
      chk("mrst_hc", s_hc[k], 0);
    end
    ones(4, 1'b0, 3, 8, "mrst_post");

    // Mode change mid-run, RUN_LEN=3, no flush
    do_reset();
    ones(3, 1'b0, 1, 4, "msw_a");
    ones(1, 1'b1, 1, 1, "msw_b");
    ones(1, 1'b0, 1, 1, "msw_c");
    ones(1, 1'b0, 1, 0, "msw_d");

    // Random stream against the run-length model; mode only changes between runs
    do_reset();
    r_ovl = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      logic rr, rc, rv, rd;
      if (m_run == 0 && $urandom_range(0, 3) == 0) r_ovl = ~r_ovl;
      rr = ($urandom_range(0, 99) == 0);
      rc = ($urandom_range(0, 15) == 0);
      rv = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 4) != 0);
      step(rc, rv, rd, r_ovl, rr);
      for (int k = 0; k < 4; k++) begin
        min_len = (m_run < max_tab[k]) ? m_run : max_tab[k];
        chk("rnd_out", int'(s_out[k]), int'(m_out[k]));
        chk("rnd_len", s_len[k], min_len);
`ifdef RUN_DETECT_STATS_EN
        chk("rnd_hc", s_hc[k], m_hc[k]);
`endif
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/run_detect_fsm.md
# run_detect_fsm

Parametrised Mealy run-length detector for a serial bit stream. Counts consecutive accepted `1` bits and asserts `out` in the same cycle as the bit that completes a run of `RUN_LEN` ones. Adds an input qualifier, overlap/non-overlap detection modes, a synchronous clear and a saturating run-length output. With `RUN_LEN=2` and overlap mode it matches the two-state count-one FSM cycle for cycle. It sits directly on serial-protocol monitors that need longer or non-overlapping patterns.

## Interface
- `RUN_LEN`, 2, ones needed for a hit; legal 1..65535
- `LEN_W`, 8, width of `run_len` output
- `STAT_W`, 16, width of `hit_count` (only with macro)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  reset; synchronous, active-high
- `clear`  in  1  synchronous flush of run state
- `mode_ovl`  in  1  1 = overlapping hits, 0 = non-overlapping
- `in_valid`  in  1  `in` is accepted this cycle
- `in`  in  1  serial data bit
- `out`  out  1  Mealy hit, combinational from state and inputs
- `run_len`  out  LEN_W  registered length of current ones run, saturating
- `hit_count`  out  STAT_W  registered total hits (macro only)

## Operation
- Internal counter `cnt_q`, width `$clog2(RUN_LEN+1)`, range 0..RUN_LEN-1.
- States (enum):
  - `ST_IDLE`: `cnt_q`=0, no ones pending.
  - `ST_RUN`: 0<`cnt_q`<RUN_LEN.
  - `ST_HIT`: previous accepted bit produced a hit.
- Accepted bit means `in_valid`=1 and `clear`=0.
- `out` = accepted && `in` && (`cnt_q`==RUN_LEN-1 || (state==`ST_HIT` && `mode_ovl`)).
- Transitions on an accepted bit:
  - `in`=0: go to `ST_IDLE`, `cnt_q`←0. Applies from any state.
  - `in`=1 and no hit: `cnt_q`+1, go to `ST_RUN`.
  - `in`=1 and hit, overlap mode: go to `ST_HIT`, `cnt_q` holds at RUN_LEN-1. Every further 1 also hits.
  - `in`=1 and hit, non-overlap mode: `cnt_q`←0, go to `ST_HIT`. The next hit needs RUN_LEN fresh ones.
  - Non-overlap mode, `ST_HIT`, `in`=1, no hit: go to `ST_RUN` with `cnt_q`=1. With RUN_LEN=1 this case is a hit instead.
- `RUN_LEN`=1: every accepted 1 hits in both modes.
- `in_valid`=0: state, `cnt_q` and `run_len` hold; `out`=0.
- `run_len`:
  - +1 on an accepted 1, saturating at 2^LEN_W−1.
  - ←0 on an accepted 0 or on `clear`.
  - Independent of mode.
- `clear`: forces `ST_IDLE`, `cnt_q`=0, `run_len`=0 at next edge; `out`=0 that cycle. `clear` wins over `in_valid`.
- `mode_ovl` is sampled every cycle. A change takes effect on the next accepted bit, with no flush.
- `out` has no registered copy; consumers register it.

## Timing
- Reset values: state `ST_IDLE`, `cnt_q`=0, `run_len`=0, `hit_count`=0. `out`=0 while `rst`=1.
- `rst` takes priority over `clear` and data. Reset mid-run discards the partial run.
- Latency: `out` has 0 cycles from the accepted bit (Mealy). `run_len` and `hit_count` update 1 cycle after the accepted bit.
- No combinational path from `in` to `run_len` or `hit_count`.

## Configuration
- Macro `RUN_DETECT_STATS_EN`.
- Defined: `hit_count` port exists. It increments on every cycle with `out`=1 and wraps modulo 2^STAT_W. It is cleared by `rst` only, not by `clear`.
- Undefined: port and counter are absent. All other behaviour is identical.

## Structure
- Package `run_detect_pkg` holds the state enum `run_state_t` (`ST_IDLE`, `ST_RUN`, `ST_HIT`) and the mode constants `MODE_NOVL`=0 and `MODE_OVL`=1.
- Two-block FSM: an `always_ff` for state, `cnt_q` and `run_len`; an `always_comb` for next state and `out`.
- One sub-module, `sat_counter`, is parametrised by width and used for `run_len`. It has a saturating or wrapping option, which `hit_count` reuses.

## Test plan
- RUN_LEN=2, overlap, `in_valid`=1, `in`=0,1,1,1,0,1 → `out`=0,0,1,1,0,0; `run_len` after each edge 0,1,2,3,0,1.
- RUN_LEN=3, non-overlap, `in`=1×7 → `out` high on the 3rd and 6th bits only. Same stream with overlap → high on bits 3–7.
- RUN_LEN=3, `in`=1,1, then `in_valid`=0 for 4 cycles, then `in`=1 → `out`=0 during the gap and 1 on the resumed bit.
- RUN_LEN=3, `in`=1,1, then `clear`=1 with `in_valid`=1, `in`=1 → `out`=0; next `in`=1,1,1 hits on the 3rd bit; `run_len` is 0 after the clear cycle.
- RUN_LEN=1, LEN_W=2, `in`=1×5 → `out`=1 every cycle; `run_len` saturates at 3.
- `rst` asserted mid-run (RUN_LEN=4 after three 1s) → all outputs 0 next cycle; four more 1s needed for a hit. With the macro defined, `hit_count` returns to 0.
